// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer: mode encoding, default timing limits
// and counter sizing helpers.
package led_sequencer_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_ALL_ON = 2'd1,
      MODE_CHASE  = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   // 10 ms debounce and 250 ms pattern step at a 25 MHz board clock
   localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
   localparam int DEFAULT_STEP_LIMIT     = 6250000;

   function automatic int cnt_width(input int limit);
      return (limit > 2) ? $clog2(limit) : 1;
   endfunction

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_OFF:    return MODE_ALL_ON;
         MODE_ALL_ON: return MODE_CHASE;
         MODE_CHASE:  return MODE_BLINK;
         MODE_BLINK:  return MODE_OFF;
         default:     return MODE_OFF;
      endcase
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// Per-switch input path: 2-flop synchronizer, optional debounce filter
// (LED_SEQ_DEBOUNCE_EN) and a one-cycle pulse on release (stable 1->0).
module switch_debounce
   import led_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic released
);

   logic meta;
   logic sync;
   logic level;
   logic level_d;

   if (DEBOUNCE_LIMIT < 1) begin : g_limit_check
      $error("switch_debounce: DEBOUNCE_LIMIT must be at least 1");
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= pin;
         sync <= meta;
      end
   end

`ifdef LED_SEQ_DEBOUNCE_EN
   localparam int            CW       = cnt_width(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

   logic [CW-1:0] cnt;
   logic          stable;

   // Accept a new level only after it has persisted for DEBOUNCE_LIMIT cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= sync;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign level = stable;
`else
   assign level = sync;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b0;
      end else begin
         level_d <= level;
      end
   end

   assign released = level_d & ~level;

endmodule

// File: rtl/led_sequencer.sv
// Go Board LED pattern controller: Switch_1 release cycles the mode, Switch_2 release
// toggles run/pause. Debounce filtering is built only when LED_SEQ_DEBOUNCE_EN is defined.
module led_sequencer
   import led_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
   parameter int STEP_LIMIT     = DEFAULT_STEP_LIMIT
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Switch_1,
   input  logic       i_Switch_2,
   output logic       o_LED_1,
   output logic       o_LED_2,
   output logic       o_LED_3,
   output logic       o_LED_4,
   output logic [1:0] o_Mode,
   output logic       o_Running
);

   localparam int            SW        = cnt_width(STEP_LIMIT);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_LIMIT - 1);

   logic          advance;
   logic          toggle;

   mode_t         mode, mode_next;
   logic          running, running_next;
   logic [SW-1:0] step_cnt, step_next;
   logic [1:0]    pos, pos_next;
   logic          phase, phase_next;
   logic [3:0]    leds, leds_next;
   logic          tick;

   switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw1 (
      .clk      (i_Clk),
      .rst      (i_Rst),
      .pin      (i_Switch_1),
      .released (advance)
   );

   switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw2 (
      .clk      (i_Clk),
      .rst      (i_Rst),
      .pin      (i_Switch_2),
      .released (toggle)
   );

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         mode     <= MODE_OFF;
         running  <= 1'b1;
         step_cnt <= '0;
         pos      <= 2'd0;
         phase    <= 1'b0;
         leds     <= 4'b0000;
      end else begin
         mode     <= mode_next;
         running  <= running_next;
         step_cnt <= step_next;
         pos      <= pos_next;
         phase    <= phase_next;
         leds     <= leds_next;
      end
   end

   always_comb begin
      mode_next    = mode;
      running_next = running;
      step_next    = step_cnt;
      pos_next     = pos;
      phase_next   = phase;
      tick         = 1'b0;
      leds_next    = 4'b0000;

      if (running) begin
         if (step_cnt == STEP_LAST) begin
            tick      = 1'b1;
            step_next = '0;
         end else begin
            step_next = step_cnt + 1'b1;
         end
      end

      if (tick) begin
         pos_next   = pos + 1'b1;
         phase_next = ~phase;
      end

      // A mode change overrides any step tick landing on the same edge
      if (advance) begin
         mode_next  = next_mode(mode);
         step_next  = '0;
         pos_next   = 2'd0;
         phase_next = 1'b1;
      end

      if (toggle) begin
         running_next = ~running;
      end

      // LEDs decode the registered pattern state, so they trail o_Mode by one edge
      case (mode)
         MODE_OFF:    leds_next = 4'b0000;
         MODE_ALL_ON: leds_next = 4'b1111;
         MODE_CHASE:  leds_next = 4'b0001 << pos;
         MODE_BLINK:  leds_next = {4{phase}};
         default:     leds_next = 4'b0000;
      endcase
   end

   assign o_LED_1   = leds[0];
   assign o_LED_2   = leds[1];
   assign o_LED_3   = leds[2];
   assign o_LED_4   = leds[3];
   assign o_Mode    = mode;
   assign o_Running = running;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with DEBOUNCE_LIMIT=4, STEP_LIMIT=8; follows
// LED_SEQ_DEBOUNCE_EN to choose the expected release latency and filter behaviour.
module tb_led_sequencer;

   localparam int DB   = 4;
   localparam int STEP = 8;
`ifdef LED_SEQ_DEBOUNCE_EN
   localparam int LAT  = 2 + DB + 2;
`else
   localparam int LAT  = 4;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] sw  = 2'b00;
   logic       led1, led2, led3, led4;
   logic [1:0] mode;
   logic       running;

   int checks   = 0;
   int failures = 0;

   led_sequencer #(.DEBOUNCE_LIMIT(DB), .STEP_LIMIT(STEP)) dut (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_Switch_1 (sw[0]),
      .i_Switch_2 (sw[1]),
      .o_LED_1    (led1),
      .o_LED_2    (led2),
      .o_LED_3    (led3),
      .o_LED_4    (led4),
      .o_Mode     (mode),
      .o_Running  (running)
   );

   always #5 clk = ~clk;

   logic [3:0] leds_v;
   logic [6:0] dut_vec;
   assign leds_v  = {led4, led3, led2, led1};
   assign dut_vec = {leds_v, mode, running};

   // Reference model: pattern derived from running cycles elapsed since the last mode entry
   logic [1:0]  m_mode;
   logic        m_run;
   logic        m_base;
   int unsigned m_elapsed;
   logic [3:0]  m_led;
   logic [1:0]  m_meta, m_sync, m_ev;
`ifdef LED_SEQ_DEBOUNCE_EN
   logic [1:0]  m_stable;
   int          m_len [2];
`endif
   logic [6:0]  exp_vec;
   assign exp_vec = {m_led, m_mode, m_run};

   function automatic logic [3:0] pattern(input logic [1:0] md, input int unsigned el,
                                          input logic base);
      int unsigned steps;
      steps = el / STEP;
      case (md)
         2'd0:    return 4'b0000;
         2'd1:    return 4'b1111;
         2'd2:    return 4'b0001 << (steps % 4);
         default: return {4{base ^ steps[0]}};
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 2'd0; m_run = 1'b1; m_base = 1'b0; m_elapsed = 0; m_led = 4'b0000;
         m_meta = 2'b00; m_sync = 2'b00; m_ev = 2'b00;
`ifdef LED_SEQ_DEBOUNCE_EN
         m_stable = 2'b00; m_len[0] = 0; m_len[1] = 0;
`endif
      end else begin
         m_led = pattern(m_mode, m_elapsed, m_base);
         if (m_ev[0]) begin
            m_mode = m_mode + 2'd1; m_elapsed = 0; m_base = 1'b1;
         end else if (m_run) begin
            m_elapsed++;
         end
         if (m_ev[1]) m_run = ~m_run;
`ifdef LED_SEQ_DEBOUNCE_EN
         for (int s = 0; s < 2; s++) begin
            m_ev[s] = 1'b0;
            if (m_sync[s] != m_stable[s]) begin
               m_len[s]++;
               if (m_len[s] == DB) begin
                  m_stable[s] = m_sync[s];
                  m_len[s]    = 0;
                  m_ev[s]     = ~m_sync[s];
               end
            end else begin
               m_len[s] = 0;
            end
         end
`else
         m_ev = m_sync & ~m_meta;
`endif
         m_sync = m_meta;
         m_meta = sw;
      end
   end

   task automatic hold(input logic [1:0] v, input int n);
      sw = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic goto_mode(input logic [1:0] target, input logic want_run);
      for (int i = 0; i < 4; i++) begin
         if (m_mode != target) begin
            hold(2'b01, 10);
            hold(2'b00, LAT + 2);
         end
      end
      if (m_run != want_run) begin
         hold(2'b10, 10);
         hold(2'b00, LAT + 2);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if (dut_vec !== 7'b0000_00_1) begin
         failures++; $display("FAIL reset_async got=%b exp=%b", dut_vec, 7'b0000001);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== 7'b0000_00_1) begin
            failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", k, dut_vec, 7'b0000001);
         end
      end
   endtask

   task automatic test_mode_advance();
      logic [1:0] want [4];
      logic [1:0] prevm;
      want = '{2'd1, 2'd2, 2'd3, 2'd0};
      for (int r = 0; r < 4; r++) begin
         prevm = want[r] - 2'd1;
         hold(2'b01, 10);
         sw = 2'b00;
         for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
               failures++; $display("FAIL mode_adv_model r=%0d k=%0d got=%b exp=%b", r, k, dut_vec, exp_vec);
            end
            if (k == LAT - 2) begin
               checks++;
               if (mode !== prevm) begin
                  failures++; $display("FAIL mode_adv_early r=%0d got=%0d exp=%0d", r, mode, prevm);
               end
            end
            if (k == LAT - 1) begin
               checks++;
               if (mode !== want[r]) begin
                  failures++; $display("FAIL mode_adv_value r=%0d got=%0d exp=%0d", r, mode, want[r]);
               end
            end
            if (r == 0 && k == LAT - 1) begin
               checks++;
               if (leds_v !== 4'b0000) begin
                  failures++; $display("FAIL all_on_early got=%b exp=%b", leds_v, 4'b0000);
               end
            end
            if (r == 0 && k == LAT) begin
               checks++;
               if (leds_v !== 4'b1111) begin
                  failures++; $display("FAIL all_on_latency got=%b exp=%b", leds_v, 4'b1111);
               end
            end
            if (r == 1 && k == LAT) begin
               checks++;
               if (leds_v !== 4'b0001) begin
                  failures++; $display("FAIL chase_entry got=%b exp=%b", leds_v, 4'b0001);
               end
            end
         end
         hold(2'b00, 5);
      end
   endtask

   task automatic test_glitch();
      logic [1:0] m0;
      m0 = m_mode;
`ifdef LED_SEQ_DEBOUNCE_EN
      hold(2'b01, 10);
      hold(2'b00, 3);
      sw = 2'b01;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         checks++;
         if (mode !== m0 || dut_vec !== exp_vec) begin
            failures++; $display("FAIL glitch_reject k=%0d got=%b exp_mode=%0d model=%b", k, dut_vec, m0, exp_vec);
         end
      end
      sw = 2'b00;
`else
      hold(2'b01, 5);
      hold(2'b00, 1);
      sw = 2'b01;
`endif
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++; $display("FAIL glitch_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
         end
      end
      checks++;
      if (mode !== m0 + 2'd1) begin
         failures++; $display("FAIL glitch_advance_once got=%0d exp=%0d", mode, m0 + 2'd1);
      end
      hold(2'b00, LAT + 2);
   endtask

   task automatic test_chase();
      logic [3:0] frozen, expl, nxt, last;
      logic       changed;
      goto_mode(2'd1, 1'b1);
      hold(2'b01, 10);
      sw = 2'b00;
      for (int k = 1; k <= LAT + 40; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++; $display("FAIL chase_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
         end
         if (k >= LAT && (k - LAT) % STEP == 0) begin
            expl = 4'b0001 << (((k - LAT) / STEP) % 4);
            checks++;
            if (leds_v !== expl) begin
               failures++; $display("FAIL chase_step k=%0d got=%b exp=%b", k, leds_v, expl);
            end
         end
      end
      hold(2'b10, 10);
      sw = 2'b00;
      repeat (LAT + 1) @(negedge clk);
      checks++;
      if (running !== 1'b0) begin
         failures++; $display("FAIL pause_flag got=%b exp=0", running);
      end
      frozen = m_led;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         checks++;
         if (leds_v !== frozen || dut_vec !== exp_vec) begin
            failures++; $display("FAIL pause_frozen k=%0d got=%b exp_leds=%b model=%b", k, dut_vec, frozen, exp_vec);
         end
      end
      hold(2'b10, 10);
      sw = 2'b00;
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (running !== 1'b1) begin
         failures++; $display("FAIL resume_flag got=%b exp=1", running);
      end
      nxt = {frozen[2:0], frozen[3]};
      changed = 1'b0;
      last = frozen;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++; $display("FAIL resume_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
         end
         if (!changed && leds_v !== last) begin
            changed = 1'b1;
            checks++;
            if (leds_v !== nxt) begin
               failures++; $display("FAIL resume_position got=%b exp=%b", leds_v, nxt);
            end
         end
      end
      if (!changed) begin
         checks++; failures++;
         $display("FAIL resume_timeout got=%b exp=%b", leds_v, nxt);
      end
   endtask

   task automatic test_simultaneous();
      goto_mode(2'd3, 1'b1);
      hold(2'b11, 10);
      sw = 2'b00;
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++; $display("FAIL simul_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
         end
         if (k == LAT - 2) begin
            checks++;
            if ({mode, running} !== 3'b11_1) begin
               failures++; $display("FAIL simul_before got=%b exp=%b", {mode, running}, 3'b111);
            end
         end
         if (k == LAT - 1) begin
            checks++;
            if ({mode, running} !== 3'b00_0) begin
               failures++; $display("FAIL simul_same_edge got=%b exp=%b", {mode, running}, 3'b000);
            end
         end
      end
   endtask

   task automatic test_random();
      int dur;
      for (int seg = 0; seg < 60; seg++) begin
         sw  = 2'($urandom_range(0, 3));
         dur = $urandom_range(1, 12);
         for (int k = 0; k < dur; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
               failures++; $display("FAIL random_model seg=%0d got=%b exp=%b", seg, dut_vec, exp_vec);
            end
         end
      end
      sw = 2'b00;
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++; $display("FAIL random_tail k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_mid_reset();
      goto_mode(2'd2, 1'b1);
      repeat (12) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dut_vec !== 7'b0000_00_1) begin
         failures++; $display("FAIL mid_reset_async got=%b exp=%b", dut_vec, 7'b0000001);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== 7'b0000_00_1 || dut_vec !== exp_vec) begin
            failures++; $display("FAIL mid_reset_idle k=%0d got=%b exp=%b", k, dut_vec, 7'b0000001);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_mode_advance();
      test_glitch();
      test_chase();
      test_simultaneous();
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
